bram_rmw_ctrl: RTL and testbench

//   Port-0 front end for the 4096x4 dual-port BRAM wrapper. The primitive ignores WEM0, so this block turns
//   bit-masked writes into read-modify-write sequences on port 0. It also passes reads through with the

---
 rtl/bram_rmw_ctrl_pkg.sv | 46 ++++
 rtl/bram_rmw_ctrl.sv | 119 +++++++++++
 tb/tb_bram_rmw_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bram_rmw_ctrl_pkg.sv
// Shared definitions for the BRAM wrapper front ends: FSM states, request
// classes, default geometry and the bit-mask merge used for read-modify-write.
package mnemosyne_bram_pkg;

    localparam int unsigned ADDR_W_DEF  = 12;
    localparam int unsigned DATA_W_DEF  = 4;
    // Widest word any front end may merge; callers size-cast in and out.
    localparam int unsigned MERGE_MAX_W = 64;

    typedef enum logic {
        IDLE,
        MERGE
    } state_e;

    typedef enum logic [1:0] {
        REQ_READ,
        REQ_FULL,
        REQ_EMPTY,
        REQ_PARTIAL
    } req_kind_e;

    function automatic logic [MERGE_MAX_W-1:0] mask_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_W-1:0] wem
    );
        return (old_word & ~wem) | (new_word & wem);
    endfunction

    function automatic req_kind_e classify(
        input logic we,
        input logic wem_full,
        input logic wem_empty
    );
        if (!we) begin
            return REQ_READ;
        end else if (wem_full) begin
            return REQ_FULL;
        end else if (wem_empty) begin
            return REQ_EMPTY;
        end else begin
            return REQ_PARTIAL;
        end
    endfunction

endpackage

// File: rtl/bram_rmw_ctrl.sv
// Port-0 front end for the dual-port BRAM: passes reads through with the
// BRAM's 1-cycle latency and turns bit-masked writes into read-modify-write.
module bram_rmw_ctrl
    import mnemosyne_bram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_DATA,
    input  logic [DATA_W-1:0] REQ_WEM,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic [ADDR_W-1:0] A0,
    output logic [DATA_W-1:0] D0,
    input  logic [DATA_W-1:0] Q0,
    output logic              WE0,
    output logic [DATA_W-1:0] WEM0,
    output logic              CE0
);

    state_e            state;
    state_e            state_next;
    req_kind_e         kind;
    logic              accept;
    logic              rsp_pending;
    logic [ADDR_W-1:0] held_addr;
    logic [DATA_W-1:0] held_data;
    logic [DATA_W-1:0] held_wem;
    logic [DATA_W-1:0] merged;

    assign REQ_READY = (state == IDLE) & ~RST;
    assign accept    = REQ_VALID & REQ_READY;
    assign kind      = classify(REQ_WE, &REQ_WEM, ~|REQ_WEM);
    assign merged    = DATA_W'(mask_merge(MERGE_MAX_W'(Q0),
                                          MERGE_MAX_W'(held_data),
                                          MERGE_MAX_W'(held_wem)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && kind == REQ_PARTIAL) state_next = MERGE;
            MERGE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        A0  = REQ_ADDR;
        D0  = REQ_DATA;
        CE0 = 1'b0;
        WE0 = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (kind)
                        REQ_READ:    CE0 = 1'b1;
                        REQ_FULL: begin
                            CE0 = 1'b1;
                            WE0 = 1'b1;
                        end
                        REQ_PARTIAL: CE0 = 1'b1;
                        default:     CE0 = 1'b0;
                    endcase
                end
            end
            MERGE: begin
                A0 = held_addr;
                D0 = merged;
                // Reset during the merge cycle drops the write so the old word survives.
                CE0 = ~RST;
                WE0 = ~RST;
            end
            default: begin
                CE0 = 1'b0;
                WE0 = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            held_addr <= '0;
            held_data <= '0;
            held_wem  <= '0;
        end else if (accept && kind == REQ_PARTIAL) begin
            held_addr <= REQ_ADDR;
            held_data <= REQ_DATA;
            held_wem  <= REQ_WEM;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_pending <= 1'b0;
        end else begin
            rsp_pending <= accept && (kind == REQ_READ);
        end
    end

    // Q0 is already registered inside the BRAM; reset in the response cycle masks it.
    assign RSP_VALID = rsp_pending & ~RST;
    assign RSP_DATA  = Q0;
    assign WEM0      = '1;

endmodule

// File: tb/tb_bram_rmw_ctrl.sv
// Directed bench for bram_rmw_ctrl with a behavioural WRITE_FIRST BRAM
// model on port 0; expected values are hand-computed.
module tb_bram_rmw_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [11:0] REQ_ADDR;
    logic [3:0]  REQ_DATA;
    logic [3:0]  REQ_WEM;
    logic        RSP_VALID;
    logic [3:0]  RSP_DATA;
    logic [11:0] A0;
    logic [3:0]  D0;
    logic [3:0]  Q0 = 4'h0;
    logic        WE0;
    logic [3:0]  WEM0;
    logic        CE0;

    int errors = 0;
    int checks = 0;

    logic [3:0] mem [0:4095];

    bram_rmw_ctrl #(.ADDR_W(12), .DATA_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_WEM(REQ_WEM),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
        .A0(A0), .D0(D0), .Q0(Q0), .WE0(WE0), .WEM0(WEM0), .CE0(CE0)
    );

    always #5 CLK = ~CLK;

    // WRITE_FIRST BRAM port 0 with registered output
    always @(posedge CLK) begin
        if (CE0) begin
            if (WE0) begin
                mem[A0] <= D0;
                Q0      <= D0;
            end else begin
                Q0 <= mem[A0];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic we, input logic [11:0] addr,
                         input logic [3:0] data, input logic [3:0] wem);
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_ADDR  = addr;
        REQ_DATA  = data;
        REQ_WEM   = wem;
    endtask

    task automatic full_write(input logic [11:0] addr, input logic [3:0] data);
        issue(1'b1, addr, data, 4'hF);
        @(negedge CLK);
        check("full_wr_we0", WE0, 1'b1);
        step();
        REQ_VALID = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [11:0] addr, input logic [3:0] exp);
        issue(1'b0, addr, 4'h0, 4'h0);
        @(negedge CLK);
        check({tag, "_ce0"}, CE0, 1'b1);
        step();
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check({tag, "_rsp_valid"}, RSP_VALID, 1'b1);
        check({tag, "_rsp_data"}, RSP_DATA, exp);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time 100000 exceeded, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1;
        issue(1'b1, 12'h001, 4'h3, 4'hF);
        step();

        // Reset held with a pending request
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rst_ready", REQ_READY, 1'b0);
            check("rst_ce0", CE0, 1'b0);
            check("rst_we0", WE0, 1'b0);
            check("rst_rsp_valid", RSP_VALID, 1'b0);
            step();
        end
        check("wem0_ones", WEM0, 4'hF);
        RST = 1'b0;
        REQ_VALID = 1'b0;
        step();

        // Full write, then a read the very next cycle
        issue(1'b1, 12'h123, 4'hA, 4'hF);
        @(negedge CLK);
        check("fw_ready", REQ_READY, 1'b1);
        check("fw_ce0", CE0, 1'b1);
        check("fw_we0", WE0, 1'b1);
        check("fw_a0", A0, 12'h123);
        check("fw_d0", D0, 4'hA);
        step();
        issue(1'b0, 12'h123, 4'h0, 4'h0);
        @(negedge CLK);
        check("rd_we0_pulse_end", WE0, 1'b0);
        check("rd_ce0", CE0, 1'b1);
        check("rd_a0", A0, 12'h123);
        check("rd_no_early_rsp", RSP_VALID, 1'b0);
        step();
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("rd_rsp_valid", RSP_VALID, 1'b1);
        check("rd_rsp_data", RSP_DATA, 4'hA);
        step();
        @(negedge CLK);
        check("rd_rsp_pulse_end", RSP_VALID, 1'b0);

        // Partial write: 0x5 merged with 0xA under mask 0x3 gives 0x6
        full_write(12'h010, 4'h5);
        issue(1'b1, 12'h010, 4'hA, 4'h3);
        @(negedge CLK);
        check("pw_ready", REQ_READY, 1'b1);
        check("pw_read_ce0", CE0, 1'b1);
        check("pw_read_we0", WE0, 1'b0);
        step();
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("pw_merge_ready", REQ_READY, 1'b0);
        check("pw_merge_we0", WE0, 1'b1);
        check("pw_merge_a0", A0, 12'h010);
        check("pw_merge_d0", D0, 4'h6);
        step();
        @(negedge CLK);
        check("pw_ready_back", REQ_READY, 1'b1);
        do_read("pw_read", 12'h010, 4'h6);

        // Streaming reads over addresses 0..7
        for (int i = 0; i < 8; i++) full_write(12'(i), 4'(i));
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 12'(i), 4'h0, 4'h0);
            @(negedge CLK);
            check("stream_ready", REQ_READY, 1'b1);
            if (i > 0) begin
                check("stream_rsp_valid", RSP_VALID, 1'b1);
                check("stream_rsp_data", RSP_DATA, 4'(i - 1));
            end
            step();
        end
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("stream_last_valid", RSP_VALID, 1'b1);
        check("stream_last_data", RSP_DATA, 4'h7);
        step();

        // Empty-mask write is a no-op
        issue(1'b1, 12'h003, 4'hC, 4'h0);
        @(negedge CLK);
        check("empty_ready", REQ_READY, 1'b1);
        check("empty_ce0", CE0, 1'b0);
        step();
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("empty_no_rsp", RSP_VALID, 1'b0);
        check("empty_ready_next", REQ_READY, 1'b1);
        step();
        do_read("empty_read", 12'h003, 4'h3);

        // Reset during MERGE aborts the write
        full_write(12'h020, 4'h9);
        issue(1'b1, 12'h020, 4'h6, 4'hC);
        step();
        REQ_VALID = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        check("abort_we0", WE0, 1'b0);
        check("abort_ce0", CE0, 1'b0);
        check("abort_rsp_valid", RSP_VALID, 1'b0);
        step();
        RST = 1'b0;
        do_read("abort_read", 12'h020, 4'h9);

        // Reset in the response cycle suppresses RSP_VALID
        issue(1'b0, 12'h020, 4'h0, 4'h0);
        step();
        REQ_VALID = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        check("rst_rsp_suppress", RSP_VALID, 1'b0);
        step();
        RST = 1'b0;
        step();

        // Back-to-back partial writes: 0x6 -> bit0 set -> 0x7 -> bit3 set -> 0xF
        full_write(12'h030, 4'h6);
        issue(1'b1, 12'h030, 4'hF, 4'h1);
        step();
        issue(1'b1, 12'h030, 4'h8, 4'h8);
        @(negedge CLK);
        check("b2b_first_ready", REQ_READY, 1'b0);
        check("b2b_first_d0", D0, 4'h7);
        step();
        @(negedge CLK);
        check("b2b_second_ready", REQ_READY, 1'b1);
        check("b2b_second_we0", WE0, 1'b0);
        step();
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("b2b_second_we0_merge", WE0, 1'b1);
        check("b2b_second_d0", D0, 4'hF);
        step();
        do_read("b2b_read", 12'h030, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
